// File: rtl/regfile_mp_if.sv
// regfile_mp_if: single-phase clock bundle for the core; ph0 is the only clock,
// and state in the core updates on its falling edge.
interface regfile_mp_if;
   logic ph0;
   modport sink (input ph0);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (IR at index 0) with pending-load scoreboard,
// hazard output and write-collision flag. Define REGFILE_BYPASS_EN for same-cycle forwarding.
module regfile_mp #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int NREAD = 2,
   localparam int IW = $clog2(DEPTH)
) (
   regfile_mp_if.sink              clk,
   input  logic                    rst,
   output logic [WIDTH-1:0]        ir,
   input  logic [IW-1:0]           mem_idx,
   input  logic [WIDTH-1:0]        mem_load,
   input  logic                    mem_load_en,
   output logic [WIDTH-1:0]        mem_store,
   input  logic [NREAD*IW-1:0]     rs_i,
   output logic [NREAD*WIDTH-1:0]  rs,
   input  logic                    alu_we,
   input  logic [IW-1:0]           alu_rd_i,
   input  logic [WIDTH-1:0]        alu_rd,
   input  logic                    sb_set_en,
   input  logic [IW-1:0]           sb_set_idx,
   output logic [DEPTH-1:0]        busy,
   output logic                    hazard,
   output logic                    wr_conflict
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic             wr_conflict_q;
   logic             alu_wr;
   logic             collide;
   logic [NREAD-1:0] rd_hz;

   assign alu_wr  = alu_we && (alu_rd_i != '0);
   assign collide = mem_load_en && alu_wr && (mem_idx == alu_rd_i);

   // ALU data wins over load data when both forward to the same index.
   function automatic logic [WIDTH-1:0] read_reg(input logic [IW-1:0] idx);
`ifdef REGFILE_BYPASS_EN
      if (alu_wr && idx == alu_rd_i) return alu_rd;
      if (mem_load_en && idx == mem_idx) return mem_load;
`endif
      return regs[idx];
   endfunction

   function automatic logic read_busy(input logic [IW-1:0] idx);
`ifdef REGFILE_BYPASS_EN
      if (mem_load_en && idx == mem_idx && !(alu_wr && idx == alu_rd_i)) return 1'b0;
`endif
      return busy_q[idx];
   endfunction

   always_ff @(negedge clk.ph0) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy_q        <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         if (mem_load_en) regs[mem_idx] <= mem_load;
         // Placed after the load write so the ALU value is the one kept on a collision.
         if (alu_wr) regs[alu_rd_i] <= alu_rd;
         if (mem_load_en) busy_q[mem_idx] <= 1'b0;
         if (sb_set_en) busy_q[sb_set_idx] <= 1'b1;
         wr_conflict_q <= collide;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [IW-1:0] idx;
      assign idx                   = rs_i[k*IW +: IW];
      assign rs[k*WIDTH +: WIDTH]  = (idx == '0) ? '0 : read_reg(idx);
      assign rd_hz[k]              = (idx != '0) && read_busy(idx);
   end

   assign ir          = read_reg('0);
   assign mem_store   = read_reg(mem_idx);
   assign busy        = busy_q;
   assign wr_conflict = wr_conflict_q;
   assign hazard      = (|rd_hz) || (alu_wr && busy_q[alu_rd_i]);

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the core, the next generation of the 16×16 core register file. It keeps the IR-at-index-0 convention, the memory load/store port and the ALU write port. It adds N read ports, an explicit ALU write enable, a pending-load scoreboard with hazard output, and write-collision detection. It sits between the sequencer, the memory unit and the ALU.

## Interface
Parameters:
- WIDTH, 16, register width in bits
- DEPTH, 16, number of registers; power of two, ≥ 4
- NREAD, 2, number of ALU read ports, 1..4
- IW, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- clk  input  Clock  codebase clock interface; the single clock is clk.ph0 and all state updates on negedge clk.ph0
- rst  input  1  synchronous, active-high reset, sampled on negedge clk.ph0
- ir  output  WIDTH  contents of register 0
- mem_idx  input  IW  memory port register index
- mem_load  input  WIDTH  load data
- mem_load_en  input  1  write mem_load into regs[mem_idx]
- mem_store  output  WIDTH  regs[mem_idx], never zero-masked
- rs_i  input  NREAD×IW  read indices, packed, port k at bits [k*IW +: IW]
- rs  output  NREAD×WIDTH  read data, packed the same way
- alu_we  input  1  ALU write enable
- alu_rd_i  input  IW  ALU destination index
- alu_rd  input  WIDTH  ALU result
- sb_set_en  input  1  mark regs[sb_set_idx] as pending a load
- sb_set_idx  input  IW  register being marked
- busy  output  DEPTH  scoreboard bits
- hazard  output  1  combinational stall request
- wr_conflict  output  1  registered one-cycle pulse on a same-index write collision

## Operation
- Read ports: rs[k] = 0 when rs_i[k] == 0, otherwise regs[rs_i[k]]. The output is combinational.
- ir = regs[0], unmasked. mem_store = regs[mem_idx], unmasked, so index 0 stores IR.
- Memory write: mem_load_en writes any index, including 0 (IR fetch).
- ALU write: performed only when alu_we = 1 and alu_rd_i ≠ 0. Writes to index 0 are discarded silently.
- Write collision: mem_load_en and an effective ALU write target the same index in one cycle.
  - The ALU value is stored.
  - wr_conflict is 1 for the following cycle.
- Writes to different indices in the same cycle both take effect.
- Scoreboard:
  - Set: sb_set_en sets busy[sb_set_idx].
  - Clear: mem_load_en clears busy[mem_idx].
  - Set and clear of the same index in one cycle leave busy = 1, because a new load is issued.
  - Set on an already-busy bit keeps it 1.
- An ALU write to a busy register is performed. busy is unchanged.
- hazard = 1 when either of these holds:
  - any rs_i[k] ≠ 0 with busy[rs_i[k]] = 1;
  - alu_we = 1, alu_rd_i ≠ 0 and busy[alu_rd_i] = 1 (write-after-load ordering).
- Reset: all registers = 0, busy = 0, wr_conflict = 0. Therefore ir = 0, mem_store = 0, every rs = 0, and hazard = 0 once inputs are idle. Reset overrides every write and scoreboard update in the same cycle.

## Timing
- Write latency: data written at negedge N is visible on ir, mem_store and rs after that edge, still within cycle N.
- busy updates at the same edge as the writes. hazard follows busy and the current indices combinationally.
- wr_conflict is asserted for exactly one cycle after the colliding edge. Back-to-back collisions hold it high.
- Reset asserted mid-operation: the state at the next edge is the reset state. Pending scoreboard bits are lost. The sequencer must reissue loads.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read ports, mem_store and ir forward same-cycle write data combinationally.
  - The ALU value has priority over mem_load on a collision, matching the stored value.
  - Index 0 masking on rs still applies.
  - A read forwarded from mem_load treats that register as not busy for hazard purposes.
- REGFILE_BYPASS_EN undefined: reads return stored state only, with one-edge write latency as above.

## Test plan
- Reset with all inputs active: after one edge all 16 registers = 0, busy = 0, wr_conflict = 0.
- ALU write, alu_we = 1, rd = 5, data 0xBEEF: after the edge rs_i[0] = 5 gives 0xBEEF. The same write with rd = 0 leaves reads of 0 returning 0 and ir unchanged.
- Memory load to index 0 with 0x1234: ir = 0x1234, rs_i = 0 still reads 0, mem_idx = 0 gives mem_store = 0x1234.
- Collision: mem_load_en with idx 3 and data 0x1111, plus ALU write with rd 3 and data 0x2222: regs[3] = 0x2222, wr_conflict = 1 for exactly the next cycle.
- Scoreboard: set idx 7, then rs_i[1] = 7 gives hazard = 1. A mem_load to 7 clears busy[7] and hazard drops. Set and clear of 7 in the same cycle leave busy[7] = 1.
- REGFILE_BYPASS_EN: ALU write to rd 9 with data 0xA5A5 while rs_i[0] = 9 makes rs[0] = 0xA5A5 in the same cycle. Without the macro, rs[0] shows the old value until the edge.
